// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial WIDTH-bit adder; optional subtract mode under SERIAL_ADD_SUB_EN

// One-nibble ripple adder reused for every nibble of the operands.
module fourbitadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// Adds a + b + cin one nibble per clock, LSB nibble first.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand B and initial carry as captured on acceptance; subtract inverts B and injects +1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // The only carry into a nibble is the registered one, so a/b never reach sum/cout combinationally.
  fourbitadder u_nib (
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (carry),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // Ready is decoded from state but forced low while reset is asserted.
  assign in_ready = (state == IDLE) & ~rst;

  // Control FSM plus operand/result shift registers; result holds outside ADD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum   <= {nib_sum, sum[WIDTH-1:4]};
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          carry <= nib_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NIBBLES - 1)) begin
            cout      <= nib_cout;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder

module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: while a result is presented, it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {15'd0, cout, sum}, 32'hDEAD);
      end else begin
        chk("result", {15'd0, cout, sum}, {15'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One transaction: accept, check latency/ignored input, back-pressure for hold cycles, release.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic tc, input logic ts, input logic [WIDTH:0] exp,
                       input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: subtract vector skipped in add-only build");
`endif
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_low_in_add", {31'd0, in_ready}, 32'd0);
      chk("busy_in_add", {31'd0, busy}, 32'd1);
      a = 16'hAAAA; b = 16'hAAAA; in_valid = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NIBBLES);
    repeat (hold) begin
      chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      chk("out_valid_held", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    chk("result_kept_in_idle", {15'd0, cout, sum}, {15'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum_cout", {15'd0, cout, sum}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    chk("sum_after_reset", {15'd0, cout, sum}, 32'd0);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 5);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF, 2);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h0_1000, 1);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 17'h1_0001, 0);

    // Abort in the second ADD cycle.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum_cout", {15'd0, cout, sum}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
    do_op(16'h0010, 16'h0020, 1'b0, 1'b0, 17'h0_0030, 0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0002, 1);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 17'h0_000D, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
